// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch stage. Issues requests to
//            instruction memory at the current PC, captures returned words into
//            a one-entry register for the decode stage, and handles
//            control-flow redirects, including redirects that arrive while a
//            request is still in flight. The in-flight response is then
//            dropped.
// Ports    : clk          - clock, rising-edge
//            rst          - asynchronous reset, active low
//            imem_req     - request valid to instruction memory
//            imem_addr    - request address
//            imem_ack     - response valid (may coincide with imem_req)
//            imem_rdata   - response instruction word
//            redirect     - control-flow change from downstream
//            redirect_pc  - new fetch target (bits [1:0] ignored)
//            id_valid     - instruction available to decode
//            id_ready     - decode accepts id_inst this cycle
//            id_inst      - registered instruction word
//            id_pc        - PC of id_inst
//            stall_cnt    - cycles with imem_req && !imem_ack, saturating
//                           (present only when FETCH_STALL_CNT_EN is defined)
// Config   : FETCH_STALL_CNT_EN - adds the stall_cnt output and its counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;   // address of the request being discarded
  logic        r_id_valid;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;

  logic        w_room;
  logic        w_req;
  logic        w_capture;
  logic        w_hold_drop;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_redirect_tgt;
  logic        w_unused;

  assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign w_unused       = &{1'b0, redirect_pc[1:0]};

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_room      = !r_id_valid || id_ready;
    w_req       = 1'b0;
    w_capture   = 1'b0;
    w_hold_drop = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A redirect in IDLE suppresses the request so the stale PC is never
        // presented to memory.
        w_req = w_room && !redirect;
        if (w_req) begin
          if (imem_ack) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        w_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DROP;
            w_hold_drop = 1'b1;
          end
        end else if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Reset must silence the request combinationally, not one edge later.
    if (!rst) begin
      w_req     = 1'b0;
      w_capture = 1'b0;
    end

    if (redirect) begin
      w_pc_nxt = w_redirect_tgt;
    end else if (w_capture) begin
      w_pc_nxt = r_pc + 32'd4;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_id_inst   <= C_NOP;
      r_id_pc     <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;

      // Memory must keep seeing the original address until the dropped
      // response returns.
      if (w_hold_drop) begin
        r_drop_addr <= r_pc;
      end

      if (redirect) begin
        r_id_valid <= 1'b0;
      end else if (w_capture) begin
        r_id_valid <= 1'b1;
        r_id_inst  <= imem_rdata;
        r_id_pc    <= r_pc;
      end else if (r_id_valid && id_ready) begin
        r_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_req && !imem_ack && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign imem_req  = w_req;
  assign imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;
  assign id_valid  = r_id_valid;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;

endmodule

`default_nettype wire
